// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, base-address table and enums for the sprite ROM
package sprite_pkg;

  localparam int SPRITE_W     = 45;
  localparam int SPRITE_WORDS = 2025;
  localparam int N_SPRITES    = 13;
  localparam int EMPTY_IDX    = 12;
  localparam int MAX_RC       = SPRITE_W - 1;
  localparam int ADDR_W       = 15;
  localparam int DATA_W       = 12;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  typedef enum logic [3:0] {
    PC_B_ROOK   = 4'd0,
    PC_B_KNIGHT = 4'd1,
    PC_B_BISHOP = 4'd2,
    PC_B_QUEEN  = 4'd3,
    PC_B_KING   = 4'd4,
    PC_B_PAWN   = 4'd5,
    PC_W_PAWN   = 4'd6,
    PC_W_ROOK   = 4'd7,
    PC_W_KNIGHT = 4'd8,
    PC_W_BISHOP = 4'd9,
    PC_W_QUEEN  = 4'd10,
    PC_W_KING   = 4'd11,
    PC_EMPTY    = 4'd12
  } piece_t;

  // First word of each sprite: index * SPRITE_WORDS.
  localparam logic [ADDR_W-1:0] SPRITE_BASE [N_SPRITES] = '{
    15'd0,     15'd2025,  15'd4050,  15'd6075,  15'd8100,
    15'd10125, 15'd12150, 15'd14175, 15'd16200, 15'd18225,
    15'd20250, 15'd22275, 15'd24300
  };

endpackage

// File: rtl/sprite_addr_calc.sv
// rtl/sprite_addr_calc.sv - clamps (piece,row,col) and forms base + row*45 + col
module sprite_addr_calc
  import sprite_pkg::*;
(
  input  logic [3:0]        i_piece,
  input  logic [5:0]        i_row,
  input  logic [5:0]        i_col,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_range_err
);

  logic              w_piece_bad;
  logic              w_row_bad;
  logic              w_col_bad;
  logic [3:0]        w_piece;
  logic [5:0]        w_row;
  logic [5:0]        w_col;
  logic [ADDR_W-1:0] w_row15;
  logic [ADDR_W-1:0] w_row_x45;

  assign w_piece_bad = (i_piece > 4'(EMPTY_IDX));
  assign w_row_bad   = (i_row > 6'(MAX_RC));
  assign w_col_bad   = (i_col > 6'(MAX_RC));

  // Bad pieces fall back to the empty tile; bad coordinates to the tile origin.
  assign w_piece = w_piece_bad ? 4'(EMPTY_IDX) : i_piece;
  assign w_row   = w_row_bad ? 6'd0 : i_row;
  assign w_col   = w_col_bad ? 6'd0 : i_col;

  assign w_row15   = {9'd0, w_row};
  assign w_row_x45 = (w_row15 << 5) + (w_row15 << 3) + (w_row15 << 2) + w_row15;

  assign o_addr      = SPRITE_BASE[w_piece] + w_row_x45 + {9'd0, w_col};
  assign o_range_err = w_piece_bad | w_row_bad | w_col_bad;

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - shares the sprite ROM between VGA (priority) and aux reader
module sprite_rom_arbiter
  import sprite_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_vga_req,
  input  logic [3:0]        i_vga_piece,
  input  logic [5:0]        i_vga_row,
  input  logic [5:0]        i_vga_col,
  input  logic              i_aux_req,
  input  logic [3:0]        i_aux_piece,
  input  logic [5:0]        i_aux_row,
  input  logic [5:0]        i_aux_col,
  output logic              o_aux_gnt,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_vga_valid,
  output logic [DATA_W-1:0] o_vga_data,
  output logic              o_aux_valid,
  output logic [DATA_W-1:0] o_aux_data,
  output logic [7:0]        o_aux_starve,
  output logic              o_range_err
);

  logic              w_issue;
  logic [3:0]        w_sel_piece;
  logic [5:0]        w_sel_row;
  logic [5:0]        w_sel_col;
  logic [ADDR_W-1:0] w_addr;
  logic              w_range_err;

  logic [ADDR_W-1:0] r_rom_addr;
  owner_t            r_tag_issue;
  owner_t            r_tag_ret;
  logic [DATA_W-1:0] r_vga_hold;
  logic [DATA_W-1:0] r_aux_hold;
  logic [7:0]        r_aux_starve;
  logic              r_range_err;

  assign w_issue     = i_vga_req | i_aux_req;
  assign w_sel_piece = i_vga_req ? i_vga_piece : i_aux_piece;
  assign w_sel_row   = i_vga_req ? i_vga_row   : i_aux_row;
  assign w_sel_col   = i_vga_req ? i_vga_col   : i_aux_col;

  sprite_addr_calc u_addr_calc (
    .i_piece     (w_sel_piece),
    .i_row       (w_sel_row),
    .i_col       (w_sel_col),
    .o_addr      (w_addr),
    .o_range_err (w_range_err)
  );

  // Owner tag walks issue -> return so rom_data is steered one cycle after rom_addr.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rom_addr  <= '0;
      r_tag_issue <= OWN_NONE;
      r_tag_ret   <= OWN_NONE;
    end else begin
      if (i_vga_req) begin
        r_rom_addr  <= w_addr;
        r_tag_issue <= OWN_VGA;
      end else if (i_aux_req) begin
        r_rom_addr  <= w_addr;
        r_tag_issue <= OWN_AUX;
      end else begin
        r_tag_issue <= OWN_NONE;
      end
      r_tag_ret <= r_tag_issue;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vga_hold   <= '0;
      r_aux_hold   <= '0;
      r_aux_starve <= '0;
      r_range_err  <= 1'b0;
    end else begin
      if (r_tag_ret == OWN_VGA) r_vga_hold <= i_rom_data;
      if (r_tag_ret == OWN_AUX) r_aux_hold <= i_rom_data;
      if (w_issue && w_range_err) r_range_err <= 1'b1;
      if (i_aux_req && i_vga_req) begin
        if (r_aux_starve != 8'hFF) r_aux_starve <= r_aux_starve + 8'd1;
      end else begin
        r_aux_starve <= '0;
      end
    end
  end

  assign o_aux_gnt    = i_aux_req & ~i_vga_req & ~i_reset;
  assign o_rom_addr   = r_rom_addr;
  assign o_vga_valid  = (r_tag_ret == OWN_VGA);
  assign o_aux_valid  = (r_tag_ret == OWN_AUX);
  // During a return the live ROM word is passed through; otherwise the last one is held.
  assign o_vga_data   = o_vga_valid ? i_rom_data : r_vga_hold;
  assign o_aux_data   = o_aux_valid ? i_rom_data : r_aux_hold;
  assign o_aux_starve = r_aux_starve;
  assign o_range_err  = r_range_err;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - randomized self-checking bench with a transaction-level reference
module tb_sprite_rom_arbiter;

  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_req, aux_req;
  logic [3:0]  vga_piece, aux_piece;
  logic [5:0]  vga_row, vga_col, aux_row, aux_col;
  logic        aux_gnt;
  logic [14:0] rom_addr;
  logic [11:0] rom_q;
  logic        vga_valid, aux_valid;
  logic [11:0] vga_data, aux_data;
  logic [7:0]  aux_starve;
  logic        range_err;

  always #5 clk = ~clk;

  sprite_rom_arbiter dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_vga_req    (vga_req),
    .i_vga_piece  (vga_piece),
    .i_vga_row    (vga_row),
    .i_vga_col    (vga_col),
    .i_aux_req    (aux_req),
    .i_aux_piece  (aux_piece),
    .i_aux_row    (aux_row),
    .i_aux_col    (aux_col),
    .o_aux_gnt    (aux_gnt),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_q),
    .o_vga_valid  (vga_valid),
    .o_vga_data   (vga_data),
    .o_aux_valid  (aux_valid),
    .o_aux_data   (aux_data),
    .o_aux_starve (aux_starve),
    .o_range_err  (range_err)
  );

  function automatic logic [11:0] rom_fn(input int a);
    int v;
    v = (a * 37) ^ (a >> 4) ^ 'h5a5;
    return v[11:0];
  endfunction

  always @(posedge clk) rom_q <= rom_fn(int'(rom_addr));

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int ret_own  [MAXC];
  int ret_addr [MAXC];
  int m_rom_addr, m_vga_last, m_aux_last, m_starve, m_range;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int ref_addr(input int p, input int r, input int c, output int bad);
    bad = (p > 12 || r > 44 || c > 44) ? 1 : 0;
    if (p > 12) p = 12;
    if (r > 44) r = 0;
    if (c > 44) c = 0;
    return p * 2025 + r * 45 + c;
  endfunction

  task automatic step();
    int a, bad, own;
    #4;
    check_eq("aux_gnt", int'(aux_gnt), int'(aux_req && !vga_req && !reset));
    check_eq("rom_addr", int'(rom_addr), m_rom_addr);
    own = ret_own[cyc];
    if (own == 1) m_vga_last = int'(rom_fn(ret_addr[cyc]));
    if (own == 2) m_aux_last = int'(rom_fn(ret_addr[cyc]));
    check_eq("vga_valid", int'(vga_valid), int'(own == 1));
    check_eq("aux_valid", int'(aux_valid), int'(own == 2));
    check_eq("vga_data", int'(vga_data), m_vga_last);
    check_eq("aux_data", int'(aux_data), m_aux_last);
    check_eq("both_valid", int'(vga_valid & aux_valid), 0);
    check_eq("aux_starve", int'(aux_starve), m_starve);
    check_eq("range_err", int'(range_err), m_range);
    if (reset) begin
      m_rom_addr = 0; m_vga_last = 0; m_aux_last = 0; m_starve = 0; m_range = 0;
      ret_own[cyc+1] = 0; ret_own[cyc+2] = 0;
    end else begin
      if (vga_req || aux_req) begin
        if (vga_req) a = ref_addr(int'(vga_piece), int'(vga_row), int'(vga_col), bad);
        else         a = ref_addr(int'(aux_piece), int'(aux_row), int'(aux_col), bad);
        ret_own[cyc+2]  = vga_req ? 1 : 2;
        ret_addr[cyc+2] = a;
        m_rom_addr = a;
        if (bad != 0) m_range = 1;
      end
      if (vga_req && aux_req) m_starve = (m_starve < 255) ? m_starve + 1 : 255;
      else m_starve = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC - 4) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 4);
      $fatal(1, "cycle budget exceeded");
    end
  endtask

  task automatic set_vga(input logic rq, input int p, input int r, input int c);
    vga_req = rq; vga_piece = 4'(p); vga_row = 6'(r); vga_col = 6'(c);
  endtask

  task automatic set_aux(input logic rq, input int p, input int r, input int c);
    aux_req = rq; aux_piece = 4'(p); aux_row = 6'(r); aux_col = 6'(c);
  endtask

  function automatic int rnd_piece();
    return ($urandom_range(0, 19) == 0) ? int'($urandom_range(13, 15)) : int'($urandom_range(0, 12));
  endfunction

  function automatic int rnd_rc();
    return ($urandom_range(0, 19) == 0) ? int'($urandom_range(45, 63)) : int'($urandom_range(0, 44));
  endfunction

  initial begin
    bit pend;
    logic gnt;
    for (int i = 0; i < MAXC; i++) begin ret_own[i] = 0; ret_addr[i] = 0; end
    m_rom_addr = 0; m_vga_last = 0; m_aux_last = 0; m_starve = 0; m_range = 0;
    reset = 1'b1;
    set_vga(0, 0, 0, 0);
    set_aux(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    step();
    set_vga(1, 3, 10, 7); step();
    set_vga(0, 0, 0, 0);  step();
    check_eq("addr_p3_r10_c7", int'(rom_addr), 6532);
    step(); step();

    set_aux(1, 12, 44, 44); step();
    set_aux(0, 0, 0, 0);    step();
    check_eq("addr_p12_r44_c44", int'(rom_addr), 26324);
    step(); step();

    set_aux(1, 5, 20, 30);
    for (int i = 0; i < 300; i++) begin
      set_vga(1, int'($urandom_range(0, 12)), int'($urandom_range(0, 44)), int'($urandom_range(0, 44)));
      step();
    end
    check_eq("starve_sat", int'(aux_starve), 255);
    set_vga(0, 0, 0, 0); step();
    check_eq("starve_clear", int'(aux_starve), 0);
    set_aux(0, 0, 0, 0); step(); step();

    set_vga(1, 14, 50, 3); step();
    set_vga(0, 0, 0, 0);   step();
    check_eq("addr_clamped", int'(rom_addr), 24303);
    check_eq("range_set", int'(range_err), 1);
    repeat (5) step();
    check_eq("range_sticky", int'(range_err), 1);

    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        set_aux(0, 0, 0, 0);
        set_vga(1, int'($urandom_range(0, 12)), int'($urandom_range(0, 44)), int'($urandom_range(0, 44)));
      end else begin
        set_vga(0, 0, 0, 0);
        set_aux(1, int'($urandom_range(0, 12)), int'($urandom_range(0, 44)), int'($urandom_range(0, 44)));
      end
      step();
    end
    set_vga(0, 0, 0, 0); set_aux(0, 0, 0, 0);
    step(); step();

    pend = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        set_aux(1, rnd_piece(), rnd_rc(), rnd_rc());
      end
      aux_req = pend;
      if ($urandom_range(0, 1) == 1) set_vga(1, rnd_piece(), rnd_rc(), rnd_rc());
      else set_vga(0, rnd_piece(), rnd_rc(), rnd_rc());
      reset = ($urandom_range(0, 99) == 0);
      gnt = aux_req & ~vga_req & ~reset;
      step();
      if (gnt) pend = 1'b0;
    end
    reset = 1'b0;
    set_vga(0, 0, 0, 0); set_aux(0, 0, 0, 0);
    step(); step();

    set_vga(1, 7, 3, 4); step();
    set_vga(0, 0, 0, 0); reset = 1'b1; step();
    reset = 1'b0; step();
    check_eq("no_valid_after_reset", int'(vga_valid), 0);
    check_eq("addr_after_reset", int'(rom_addr), 0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
